// File: rtl/mem_responder.sv
// Word-addressed memory responder: captures a request, inserts WAIT_CYCLES wait states, then acks.
// Optional MEM_RESPONDER_BOUNDS_CHECK_EN flags misaligned/out-of-range addresses with err.
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned LP_WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  w_capture;
  logic                  w_enter_resp;
  logic                  r_we;
  logic [31:0]           r_addr, r_wdata, r_rdata;
  logic                  w_we;
  logic [31:0]           w_addr, w_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_bad;
  logic [31:0]           r_mem [LP_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture = 1'b1;
          if (LP_WAIT == 4'd0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LP_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use the live inputs there.
  assign w_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];

  assign w_enter_resp = rst && (w_next == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_enter_resp && !w_bad) begin
      r_rdata <= w_we ? w_wdata : r_mem[w_idx];
    end
  end

  // Storage is deliberately left out of reset so contents survive an aborted access.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_bad) r_mem[w_idx] <= w_wdata;
  end

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  logic r_err;
  assign w_bad = (w_addr[1:0] != 2'b00) || (w_addr[31:DEPTH_LOG2+2] != '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_err <= 1'b0;
    else if (w_enter_resp) r_err <= w_bad;
  end
  assign err = r_err;
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign w_unused = ^{w_addr[31:DEPTH_LOG2+2], w_addr[1:0]};
  assign err      = 1'b0;
`endif

  assign rdata = r_rdata;
  assign ack   = (r_state == S_RESP);
  assign busy  = (r_state != S_IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, meaning log2 of the number of 32-bit words stored (64 words).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning the number of wait states inserted before each response (legal range 0..15).
REQ-003 Port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, meaning the asynchronous, active-low reset (0 = reset).
REQ-005 Port req, input, 1 bit, meaning the initiator requests an access this cycle.
REQ-006 Port we, input, 1 bit, meaning the request is a write when 1 and a read when 0.
REQ-007 Port addr, input, 32 bits, meaning the byte address; the word index is addr[DEPTH_LOG2+1:2].
REQ-008 Port wdata, input, 32 bits, meaning the write data.
REQ-009 Port rdata, output, 32 bits, meaning the registered response data.
REQ-010 Port ack, output, 1 bit, meaning a one-cycle pulse that marks the response cycle.
REQ-011 Port busy, output, 1 bit, meaning a request is in progress (state is not IDLE).
REQ-012 Port err, output, 1 bit, meaning the response is an error; it is valid only while ack=1.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT and RESP; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 In IDLE, at a rising edge k with req=1, the block SHALL capture we, addr and wdata into internal registers.
- REQ-014 continued: the block SHALL go to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-015 In WAIT, the counter SHALL decrement at every edge; at the edge where counter=1 the block SHALL enter RESP.
- REQ-015 consequence: RESP begins at edge k+WAIT_CYCLES.
REQ-016 On the edge that enters RESP, the block SHALL perform the captured access:
- Write: store the captured wdata and load rdata with that wdata.
- Read: load rdata with the stored word.
REQ-017 ack SHALL be 1 for exactly the one cycle spent in RESP; RESP SHALL always return to IDLE on the next edge.
REQ-018 req, we, addr and wdata SHALL be ignored while busy=1; they need not be held after edge k.
REQ-019 With req held continuously high, the block SHALL accept a new request at each IDLE edge.
- REQ-019 consequence: the request period is WAIT_CYCLES+2 cycles.
REQ-020 rdata SHALL hold its value between acks.
REQ-021 addr[31:DEPTH_LOG2+2] and addr[1:0] SHALL be handled only as specified under Configuration.

Reset
REQ-022 When rst=0, the block SHALL asynchronously force the state to IDLE, counter=0, ack=0, busy=0, err=0 and rdata=32'h0.
REQ-023 A reset during WAIT or RESP SHALL abort the access: no write is committed unless the RESP-entry edge has already occurred, and no ack is issued.
REQ-024 Reset SHALL NOT alter the stored memory contents.
REQ-025 After rst returns to 1, the first request SHALL be accepted at the first rising edge with req=1.

Configuration
REQ-026 The block SHALL support the macro MEM_RESPONDER_BOUNDS_CHECK_EN.
- Defined: a request with addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0 SHALL complete with the normal latency and ack, with err=1, rdata unchanged and no write.
- Undefined: err SHALL be tied to 0; address bits outside the index SHALL be ignored, so accesses wrap modulo 2^DEPTH_LOG2 words.

Verification
REQ-027 Write then read: write addr=32'h10, wdata=32'hDEADBEEF with WAIT_CYCLES=2 -> ack at edge k+2; a following read of 32'h10 -> rdata=32'hDEADBEEF on its ack, err=0.
REQ-028 Latency sweep: WAIT_CYCLES=0, 1 and 5 -> ack high exactly in the cycle after edge k+WAIT_CYCLES, for one cycle only; busy=1 from edge k until ack ends.
REQ-029 Busy-ignore: during WAIT, pulse req with we=1, addr=32'h20, wdata=32'h1234 -> no second ack and mem[8] unchanged; req held high -> accept period = WAIT_CYCLES+2.
REQ-030 Reset mid-access: assert rst=0 during WAIT of a write of 32'hCAFEF00D to 32'h04 -> ack, busy and rdata go 0 immediately; a later read of 32'h04 returns its pre-reset value.
REQ-031 Bounds, macro defined: read of 32'h102 -> ack with err=1, rdata unchanged; write of 32'h400 (DEPTH_LOG2=6) -> err=1 and mem[0] unchanged.
REQ-032 Bounds, macro undefined: write 32'hA5A5A5A5 to 32'h400 -> a read of 32'h0 returns 32'hA5A5A5A5 and err stays 0.
